// File: rtl/fifo_push_arbiter_pkg.sv
// Shared defaults and width helpers for the fifo push arbiter.
// Also used by any other scheduler that attaches to the same sample fifo.
package fifo_push_arbiter_pkg;

  localparam int DEF_NUM_REQ      = 4;
  localparam int DEF_DW           = 32;
  localparam int DEF_DEPTH        = 16;
  localparam int DEF_AFULL_THRESH = 12;

  // Width of a sample count able to hold every value 0..depth inclusive.
  function automatic int count_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fifo_push_arbiter_rr_pick.sv
// Combinational round-robin picker: the first set bit of eligible_i at or after
// ptr_i, searching upward with wrap-around modulo N.
module fifo_push_arbiter_rr_pick
  import fifo_push_arbiter_pkg::*;
#(
  parameter int N  = DEF_NUM_REQ,
  parameter int PW = ptr_width(N)
) (
  input  logic [N-1:0]  eligible_i,
  input  logic [PW-1:0] ptr_i,
  output logic [N-1:0]  grant_o,
  output logic [PW-1:0] idx_o,
  output logic          valid_o
);

  logic [PW:0] cand;

  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    cand    = '0;
    for (int k = 0; k < N; k++) begin
      // Explicit wrap, so N need not be a power of two.
      cand = {1'b0, ptr_i} + (PW+1)'(k);
      if (cand >= (PW+1)'(N)) begin
        cand = cand - (PW+1)'(N);
      end
      if (!valid_o && eligible_i[cand[PW-1:0]]) begin
        valid_o                = 1'b1;
        idx_o                  = cand[PW-1:0];
        grant_o[cand[PW-1:0]]  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_push_arbiter.sv
// Round-robin sharing of one fifo write port between NUM_REQ producers.
// The attached fifo's own reset is active-high: drive it from ~wb_rst_n.
module fifo_push_arbiter
  import fifo_push_arbiter_pkg::*;
#(
  parameter int NUM_REQ      = DEF_NUM_REQ,
  parameter int DW           = DEF_DW,
  parameter int DEPTH        = DEF_DEPTH,
  parameter int AFULL_THRESH = DEF_AFULL_THRESH
) (
  input  logic                          wb_clk,
  input  logic                          wb_rst_n,
  input  logic                          enable,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DW-1:0]         req_data,
  output logic [NUM_REQ-1:0]            ack,
  output logic                          fifo_push,
  output logic [DW-1:0]                 fifo_data_in,
  input  logic                          fifo_full,
  input  logic [count_width(DEPTH)-1:0] fifo_number_samples,
  output logic                          almost_full,
  output logic                          idle
);

  localparam int CW = count_width(DEPTH);
  localparam int LW = CW + 1;
  localparam int PW = ptr_width(NUM_REQ);

  logic               push_q, push_d;
  logic [NUM_REQ-1:0] ack_q, ack_d;
  logic [DW-1:0]      data_q, data_d;
  logic               afull_q, afull_d;
  logic [PW-1:0]      ptr_q, ptr_d;

  logic [LW-1:0]      level;
  logic               blocked;
  logic [NUM_REQ-1:0] eligible;
  logic [NUM_REQ-1:0] pick_grant;
  logic [PW-1:0]      pick_idx;
  logic               pick_valid;
  logic               grant_ok;

  // The push issued last cycle is not yet reflected in number_samples.
  assign level    = {1'b0, fifo_number_samples} + LW'(push_q);
  assign blocked  = !enable || fifo_full || (level >= LW'(DEPTH));
  // A requester acked this cycle still shows its old word, so skip it.
  assign eligible = req & ~ack_q;
  assign grant_ok = pick_valid && !blocked;

  fifo_push_arbiter_rr_pick #(
    .N  (NUM_REQ),
    .PW (PW)
  ) u_pick (
    .eligible_i (eligible),
    .ptr_i      (ptr_q),
    .grant_o    (pick_grant),
    .idx_o      (pick_idx),
    .valid_o    (pick_valid)
  );

  always_comb begin
    push_d  = grant_ok;
    ack_d   = grant_ok ? pick_grant : '0;
    data_d  = grant_ok ? req_data[pick_idx*DW +: DW] : data_q;
    afull_d = (level >= LW'(AFULL_THRESH));
    ptr_d   = ptr_q;
    if (grant_ok) begin
      ptr_d = (pick_idx == PW'(NUM_REQ - 1)) ? '0 : pick_idx + PW'(1);
    end
  end

  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      push_q  <= 1'b0;
      ack_q   <= '0;
      data_q  <= '0;
      afull_q <= 1'b0;
      ptr_q   <= '0;
    end else begin
      push_q  <= push_d;
      ack_q   <= ack_d;
      data_q  <= data_d;
      afull_q <= afull_d;
      ptr_q   <= ptr_d;
    end
  end

  assign ack          = ack_q;
  assign fifo_push    = push_q;
  assign fifo_data_in = data_q;
  assign almost_full  = afull_q;
  assign idle         = (req == '0) && !push_q;

endmodule

// File: tb/tb_fifo_push_arbiter.sv
// Bench for fifo_push_arbiter: a behavioural fifo, scripted producers and a
// grant-rule reference model; each scenario task checks against them.
module tb_fifo_push_arbiter;

  localparam int NUM_REQ = 4;
  localparam int DW      = 32;
  localparam int DEPTH   = 16;
  localparam int AFULL   = 12;
  localparam int CW      = $clog2(DEPTH) + 1;

  logic                  wb_clk   = 1'b0;
  logic                  wb_rst_n = 1'b1;
  logic                  enable   = 1'b0;
  logic [NUM_REQ-1:0]    req      = '0;
  logic [NUM_REQ*DW-1:0] req_data = '0;
  logic [NUM_REQ-1:0]    ack;
  logic                  fifo_push;
  logic [DW-1:0]         fifo_data_in;
  logic                  fifo_full;
  logic [CW-1:0]         fifo_number_samples;
  logic                  almost_full;
  logic                  idle;
  logic                  pop = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 wb_clk = ~wb_clk;

  fifo_push_arbiter #(
    .NUM_REQ      (NUM_REQ),
    .DW           (DW),
    .DEPTH        (DEPTH),
    .AFULL_THRESH (AFULL)
  ) dut (
    .wb_clk              (wb_clk),
    .wb_rst_n            (wb_rst_n),
    .enable              (enable),
    .req                 (req),
    .req_data            (req_data),
    .ack                 (ack),
    .fifo_push           (fifo_push),
    .fifo_data_in        (fifo_data_in),
    .fifo_full           (fifo_full),
    .fifo_number_samples (fifo_number_samples),
    .almost_full         (almost_full),
    .idle                (idle)
  );

  // Behavioural fifo with an active-high reset taken from ~wb_rst_n.
  logic [DW-1:0] fmem [DEPTH];
  int frd = 0, fwr = 0, fcount = 0, ovf = 0;

  always @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      frd    <= 0;
      fwr    <= 0;
      fcount <= 0;
    end else begin
      if (fifo_push && fcount < DEPTH) begin
        fmem[fwr] <= fifo_data_in;
        fwr       <= (fwr + 1) % DEPTH;
      end
      if (fifo_push && fcount >= DEPTH) ovf <= ovf + 1;
      if (pop && fcount > 0) frd <= (frd + 1) % DEPTH;
      fcount <= fcount + ((fifo_push && fcount < DEPTH) ? 1 : 0) - ((pop && fcount > 0) ? 1 : 0);
    end
  end

  assign fifo_number_samples = CW'(fcount);
  assign fifo_full           = (fcount == DEPTH);

  // Reference model: grant rules evaluated with integer arithmetic.
  logic               m_push  = 1'b0;
  logic [NUM_REQ-1:0] m_ack   = '0;
  logic [DW-1:0]      m_data  = '0;
  logic               m_afull = 1'b0;
  int                 m_ptr   = 0;
  int                 m_level;
  int                 m_win;

  always_comb begin
    m_level = fcount + (m_push ? 1 : 0);
    m_win   = -1;
    if (enable && !fifo_full && m_level < DEPTH) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        if (m_win < 0 && req[(m_ptr + k) % NUM_REQ] && !m_ack[(m_ptr + k) % NUM_REQ])
          m_win = (m_ptr + k) % NUM_REQ;
      end
    end
  end

  always @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      m_push  <= 1'b0;
      m_ack   <= '0;
      m_data  <= '0;
      m_afull <= 1'b0;
      m_ptr   <= 0;
    end else begin
      m_push  <= (m_win >= 0);
      m_ack   <= (m_win >= 0) ? (NUM_REQ'(1) << m_win) : '0;
      m_afull <= (m_level >= AFULL);
      if (m_win >= 0) begin
        m_data <= req_data[m_win*DW +: DW];
        m_ptr  <= (m_win + 1) % NUM_REQ;
      end
    end
  end

  // Scripted producers: src_left words remain, src_word is the one presented.
  int            src_left [NUM_REQ];
  logic [DW-1:0] src_word [NUM_REQ];

  task automatic drive_reqs();
    for (int k = 0; k < NUM_REQ; k++) begin
      if (ack[k] && req[k] && src_left[k] > 0) begin
        src_left[k]--;
        src_word[k]++;
      end
      req[k]               = (src_left[k] > 0);
      req_data[k*DW +: DW] = src_word[k];
    end
  endtask

  function automatic int onehot_idx(input logic [NUM_REQ-1:0] v);
    for (int k = 0; k < NUM_REQ; k++) if (v[k]) return k;
    return -1;
  endfunction

  task automatic test_reset();
    for (int k = 0; k < NUM_REQ; k++) begin src_left[k] = 0; src_word[k] = '0; end
    drive_reqs();
    #1 wb_rst_n = 1'b0;
    #1;
    n_checks++;
    if ({fifo_push, ack, almost_full, idle, fifo_data_in} !== {1'b1 ^ 1'b1, {NUM_REQ{1'b0}}, 1'b0, 1'b1, {DW{1'b0}}}) begin
      n_fail++;
      $display("FAIL reset_outputs: got push=%b ack=%b af=%b idle=%b data=%h want 0/0/0/1/0",
               fifo_push, ack, almost_full, idle, fifo_data_in);
    end
    repeat (2) @(negedge wb_clk);
    wb_rst_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge wb_clk);
      n_checks++;
      if (fifo_push !== 1'b0 || ack !== '0 || idle !== 1'b1) begin
        n_fail++;
        $display("FAIL reset_quiet cyc %0d: got push=%b ack=%b idle=%b want 0/0/1", c, fifo_push, ack, idle);
      end
    end
  endtask

  task automatic test_round_robin();
    int order[$];
    int first_c = -1, last_c = -1;
    enable = 1'b1;
    for (int k = 0; k < NUM_REQ; k++) begin src_word[k] = DW'(32'hA0 + k); src_left[k] = 1; end
    drive_reqs();
    for (int c = 0; c < 8; c++) begin
      @(negedge wb_clk);
      n_checks++;
      if ({fifo_push, ack, almost_full, idle, fifo_data_in} !== {m_push, m_ack, m_afull, (req == '0) && !m_push, m_data}) begin
        n_fail++;
        $display("FAIL rr_model cyc %0d: got push=%b ack=%b af=%b idle=%b data=%h want %b/%b/%b/%b/%h",
                 c, fifo_push, ack, almost_full, idle, fifo_data_in, m_push, m_ack, m_afull, (req == '0) && !m_push, m_data);
      end
      if (ack != '0) begin
        order.push_back(onehot_idx(ack));
        if (first_c < 0) first_c = c;
        last_c = c;
      end
      drive_reqs();
    end
    n_checks++;
    if (order.size() != 4 || last_c - first_c != 3) begin
      n_fail++;
      $display("FAIL rr_burst: got %0d acks over %0d cycles want 4 over 4", order.size(), last_c - first_c + 1);
    end
    for (int i = 0; i < order.size() && i < 4; i++) begin
      n_checks++;
      if (order[i] != i) begin
        n_fail++;
        $display("FAIL rr_order grant %0d: got requester %0d want %0d", i, order[i], i);
      end
    end
    n_checks++;
    if (fcount != 4) begin n_fail++; $display("FAIL rr_level: got %0d want 4", fcount); end
    for (int i = 0; i < 4; i++) begin
      @(negedge wb_clk);
      n_checks++;
      if (fmem[frd] !== DW'(32'hA0 + i)) begin
        n_fail++;
        $display("FAIL rr_readback %0d: got %h want %h", i, fmem[frd], DW'(32'hA0 + i));
      end
      pop = 1'b1;
    end
    @(negedge wb_clk);
    pop = 1'b0;
  endtask

  task automatic test_enable();
    int order[$];
    enable = 1'b0;
    src_word[0] = DW'(32'h50); src_left[0] = 1;
    src_word[2] = DW'(32'h52); src_left[2] = 1;
    drive_reqs();
    for (int c = 0; c < 8; c++) begin
      @(negedge wb_clk);
      n_checks++;
      if (fifo_push !== 1'b0 || ack !== '0 || req !== 4'b0101) begin
        n_fail++;
        $display("FAIL enable_hold cyc %0d: got push=%b ack=%b req=%b want 0/0000/0101", c, fifo_push, ack, req);
      end
      drive_reqs();
    end
    enable = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge wb_clk);
      n_checks++;
      if ({fifo_push, ack, almost_full, idle, fifo_data_in} !== {m_push, m_ack, m_afull, (req == '0) && !m_push, m_data}) begin
        n_fail++;
        $display("FAIL enable_model cyc %0d: got push=%b ack=%b af=%b idle=%b data=%h want %b/%b/%b/%b/%h",
                 c, fifo_push, ack, almost_full, idle, fifo_data_in, m_push, m_ack, m_afull, (req == '0) && !m_push, m_data);
      end
      if (ack != '0) order.push_back(onehot_idx(ack));
      drive_reqs();
    end
    n_checks++;
    if (order.size() != 2 || order[0] != 0 || order[1] != 2) begin
      n_fail++;
      $display("FAIL enable_order: got %0d grants first=%0d want 2 grants 0 then 2",
               order.size(), (order.size() > 0) ? order[0] : -1);
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge wb_clk);
      n_checks++;
      if (fmem[frd] !== DW'(32'h50 + 2 * i)) begin
        n_fail++;
        $display("FAIL enable_readback %0d: got %h want %h", i, fmem[frd], DW'(32'h50 + 2 * i));
      end
      pop = 1'b1;
    end
    @(negedge wb_clk);
    pop = 1'b0;
  endtask

  task automatic test_single();
    int acyc[$];
    src_word[2] = DW'(32'h22); src_left[2] = 6;
    drive_reqs();
    for (int c = 0; c < 20; c++) begin
      @(negedge wb_clk);
      n_checks++;
      if ({fifo_push, ack, almost_full, idle, fifo_data_in} !== {m_push, m_ack, m_afull, (req == '0) && !m_push, m_data}) begin
        n_fail++;
        $display("FAIL single_model cyc %0d: got push=%b ack=%b af=%b idle=%b data=%h want %b/%b/%b/%b/%h",
                 c, fifo_push, ack, almost_full, idle, fifo_data_in, m_push, m_ack, m_afull, (req == '0) && !m_push, m_data);
      end
      if (ack[2]) acyc.push_back(c);
      drive_reqs();
    end
    n_checks++;
    if (acyc.size() != 6) begin n_fail++; $display("FAIL single_count: got %0d acks want 6", acyc.size()); end
    for (int i = 1; i < acyc.size(); i++) begin
      n_checks++;
      if (acyc[i] - acyc[i-1] != 2) begin
        n_fail++;
        $display("FAIL single_gap %0d: got %0d cycles want 2", i, acyc[i] - acyc[i-1]);
      end
    end
    for (int i = 0; i < 6; i++) begin
      @(negedge wb_clk);
      n_checks++;
      if (fmem[frd] !== DW'(32'h22 + i)) begin
        n_fail++;
        $display("FAIL single_readback %0d: got %h want %h", i, fmem[frd], DW'(32'h22 + i));
      end
      pop = 1'b1;
    end
    @(negedge wb_clk);
    pop = 1'b0;
  endtask

  task automatic test_full();
    int grant_c = -1;
    src_word[1] = DW'(32'h100); src_left[1] = 17;
    drive_reqs();
    for (int c = 0; c < 60; c++) begin
      @(negedge wb_clk);
      n_checks++;
      if ({fifo_push, ack, almost_full, idle, fifo_data_in} !== {m_push, m_ack, m_afull, (req == '0) && !m_push, m_data}) begin
        n_fail++;
        $display("FAIL full_model cyc %0d: got push=%b ack=%b af=%b idle=%b data=%h want %b/%b/%b/%b/%h",
                 c, fifo_push, ack, almost_full, idle, fifo_data_in, m_push, m_ack, m_afull, (req == '0) && !m_push, m_data);
      end
      drive_reqs();
      if (fcount == DEPTH) break;
    end
    n_checks++;
    if (fcount != DEPTH || almost_full !== 1'b1 || req[1] !== 1'b1) begin
      n_fail++;
      $display("FAIL full_reached: got level=%0d af=%b req1=%b want %0d/1/1", fcount, almost_full, req[1], DEPTH);
    end
    for (int c = 0; c < 20; c++) begin
      @(negedge wb_clk);
      n_checks++;
      if (fifo_push !== 1'b0 || ack !== '0 || almost_full !== 1'b1) begin
        n_fail++;
        $display("FAIL full_hold cyc %0d: got push=%b ack=%b af=%b want 0/0000/1", c, fifo_push, ack, almost_full);
      end
      drive_reqs();
    end
    pop = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge wb_clk);
      pop = 1'b0;
      n_checks++;
      if ({fifo_push, ack, almost_full, idle, fifo_data_in} !== {m_push, m_ack, m_afull, (req == '0) && !m_push, m_data}) begin
        n_fail++;
        $display("FAIL full_pop_model cyc %0d: got push=%b ack=%b af=%b idle=%b data=%h want %b/%b/%b/%b/%h",
                 c, fifo_push, ack, almost_full, idle, fifo_data_in, m_push, m_ack, m_afull, (req == '0) && !m_push, m_data);
      end
      if (ack[1] && grant_c < 0) grant_c = c;
      drive_reqs();
    end
    n_checks++;
    if (grant_c != 1 || fcount != DEPTH) begin
      n_fail++;
      $display("FAIL full_regrant: got ack at step %0d level=%0d want step 1 level=%0d", grant_c, fcount, DEPTH);
    end
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge wb_clk);
      n_checks++;
      if (fmem[frd] !== DW'(32'h101 + i)) begin
        n_fail++;
        $display("FAIL full_readback %0d: got %h want %h", i, fmem[frd], DW'(32'h101 + i));
      end
      pop = 1'b1;
    end
    @(negedge wb_clk);
    pop = 1'b0;
  endtask

  task automatic test_reset_mid();
    int order[$];
    bit seen = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin src_word[k] = DW'(32'hC0 + k); src_left[k] = 1; end
    drive_reqs();
    for (int c = 0; c < 6; c++) begin
      @(negedge wb_clk);
      if (ack[2]) begin seen = 1'b1; break; end
      drive_reqs();
    end
    n_checks++;
    if (!seen || fifo_push !== 1'b1 || fifo_data_in !== DW'(32'hC2)) begin
      n_fail++;
      $display("FAIL midrst_setup: got ack2=%b push=%b data=%h want 1/1/%h", seen, fifo_push, fifo_data_in, DW'(32'hC2));
    end
    #2 wb_rst_n = 1'b0;
    #1;
    n_checks++;
    if ({fifo_push, ack, almost_full, fifo_data_in} !== {1'b0, {NUM_REQ{1'b0}}, 1'b0, {DW{1'b0}}}) begin
      n_fail++;
      $display("FAIL midrst_async: got push=%b ack=%b af=%b data=%h want 0/0000/0/0", fifo_push, ack, almost_full, fifo_data_in);
    end
    @(negedge wb_clk);
    for (int k = 0; k < NUM_REQ; k++) begin src_word[k] = DW'(32'hD0 + k); src_left[k] = 1; end
    drive_reqs();
    wb_rst_n = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge wb_clk);
      n_checks++;
      if ({fifo_push, ack, almost_full, idle, fifo_data_in} !== {m_push, m_ack, m_afull, (req == '0) && !m_push, m_data}) begin
        n_fail++;
        $display("FAIL midrst_model cyc %0d: got push=%b ack=%b af=%b idle=%b data=%h want %b/%b/%b/%b/%h",
                 c, fifo_push, ack, almost_full, idle, fifo_data_in, m_push, m_ack, m_afull, (req == '0) && !m_push, m_data);
      end
      if (ack != '0) order.push_back(onehot_idx(ack));
      drive_reqs();
    end
    n_checks++;
    if (order.size() != 4 || order[0] != 0) begin
      n_fail++;
      $display("FAIL midrst_first: got %0d grants first=%0d want 4 grants first 0",
               order.size(), (order.size() > 0) ? order[0] : -1);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge wb_clk);
      n_checks++;
      if (fmem[frd] !== DW'(32'hD0 + i)) begin
        n_fail++;
        $display("FAIL midrst_readback %0d: got %h want %h", i, fmem[frd], DW'(32'hD0 + i));
      end
      pop = 1'b1;
    end
    @(negedge wb_clk);
    pop = 1'b0;
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_enable();
    test_single();
    test_full();
    test_reset_mid();
    n_checks++;
    if (ovf != 0) begin
      n_fail++;
      $display("FAIL overflow: got %0d pushes into a full fifo want 0", ovf);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_push_arbiter.md
Name: fifo_push_arbiter

Overview:
- Shares one fifo write port between NUM_REQ independent producers (DSP channel front-ends) using round-robin arbitration.
- Drives the fifo's push/data_in and watches its full/number_samples, so the fifo never overflows and no sample is dropped.
- Also provides an almost-full flag for the Wishbone register/IRQ block.
- Sits between the producers and one fifo instance in the wb_dsp datapath.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
DW, 32, sample data width, must match the fifo's data width
DEPTH, 16, depth of the attached fifo
AFULL_THRESH, 12, level at or above which almost_full asserts (1..DEPTH)

Ports:
wb_clk  in  1  system clock, all logic on rising edge
wb_rst_n  in  1  asynchronous active-low reset
enable  in  1  1 = arbitration allowed; 0 = no new grants
req  in  NUM_REQ  per-requester level request; held with data until acked
req_data  in  NUM_REQ*DW  requester k data at bits [k*DW +: DW]
ack  out  NUM_REQ  registered one-cycle pulse: requester's word was pushed
fifo_push  out  1  to fifo push
fifo_data_in  out  DW  to fifo data_in
fifo_full  in  1  from fifo full
fifo_number_samples  in  $clog2(DEPTH)+1  from fifo number_samples
almost_full  out  1  registered flag: effective level >= AFULL_THRESH
idle  out  1  no request pending and no push in flight

Behaviour:
- Reset (wb_rst_n low, takes effect immediately, no clock needed):
  - ack=0, fifo_push=0, fifo_data_in=0, almost_full=0, idle=1.
  - Round-robin pointer is reset to 0, so requester 0 has top priority.
  - The fifo uses an active-high reset; the top level drives it from the inverted wb_rst_n.
- Effective level: level = fifo_number_samples + fifo_push. This counts a push that has been issued but not yet seen by the fifo.
- Blocked when any of the following holds: enable=0, fifo_full=1, or level >= DEPTH.
- Eligible requesters: eligible = req & ~ack. A requester is never re-granted in the cycle its ack is high, because it is still presenting the old word.
- Grant (cycle t, not blocked, eligible != 0):
  - Winner w is the first eligible index at or after the pointer, searching upward and wrapping modulo NUM_REQ.
  - At the rising edge: fifo_push<=1, fifo_data_in<=req_data[w], ack[w]<=1, pointer<=(w+1) mod NUM_REQ.
- No grant: fifo_push<=0, ack<=0, fifo_data_in holds its last value, pointer unchanged.
- Latency: req seen in cycle t produces fifo_push/ack in cycle t+1. The fifo captures the word at the end of cycle t+1.
- Throughput:
  - Several requesters can be served back-to-back at one push per cycle.
  - A single continuous requester gets at most one push every 2 cycles, due to the ack mask.
- Fairness: with NUM_REQ requesters continuously asserted, each requester is granted once per NUM_REQ grants.
- Requester rule: after ack, a requester either deasserts req or presents its next word in the following cycle. req_data must stay stable while req=1 and no ack has arrived.
- Full boundary:
  - No grant while level >= DEPTH.
  - After a pop reduces number_samples below DEPTH, a grant can occur in that same cycle.
- Simultaneous fifo pop and arbiter push are legal. The arbiter never drives pop.
- enable falling mid-stream: a push already registered still completes. No further grants; pending requests stay pending, with no ack and no loss.
- almost_full <= (level >= AFULL_THRESH), registered.
- idle = (req == 0) && !fifo_push, combinational.
- Width rules:
  - level is computed at $clog2(DEPTH)+2 bits to avoid overflow.
  - The pointer is $clog2(NUM_REQ) bits, with explicit wrap when NUM_REQ is not a power of 2.

Decomposition:
- Shared include (dsp_defines): default DW, DEPTH, NUM_REQ, plus a clog2-derived width constant for sample counts.
- Sub-module rr_pick: combinational round-robin priority picker.
  - Inputs: eligible vector, pointer.
  - Outputs: one-hot grant, winner index, valid.
  - Reusable by a future pop-side scheduler.
- The top level holds the registers, level/block logic and almost_full.

Test Plan:
- Reset: drive wb_rst_n=0 mid-clock -> all outputs 0 and idle=1 immediately. After release with req=0, fifo_push stays 0 for 10 cycles.
- Round-robin order (NUM_REQ=4, DW=32, DEPTH=16): req=4'b1111 with data 0x0000_00A0..A3 for one burst -> ack pulses 0,1,2,3 on 4 consecutive cycles and the fifo reads back A0,A1,A2,A3.
- Single requester: req[2]=1 continuously, data incremented on each ack from 0x22 -> ack[2] every other cycle and the fifo holds 0x22,0x23,... in order.
- Full handling: 16 pushes from requester 1 -> number_samples=16, almost_full=1 from level 12 onward. A 17th req is held with no ack and fifo_push=0 for 20 cycles. One pop -> the grant occurs within 1 cycle and number_samples returns to 16.
- enable gating: enable=0 with req=4'b0101 -> no push for 8 cycles. enable=1 -> grants to requester 0 then requester 2.
- Reset mid-operation: assert wb_rst_n=0 while fifo_push=1 and pointer=3 -> fifo_push and ack drop at once. After release with req=4'b1111, requester 0 is granted first.
